alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, multi-cycle execute unit for the RISC-V integer core, succeeding the single-cycle combinational ALU. It covers add/sub/shift, branch and JALR resolution, and iterative RV32M-style multiply and divide. Operands are captured through a valid/ready handshake, and results are held registered until consumed. It sits between decode/register-read and writeback/PC-select.

## Interface
- XLEN, 32: datapath width; power of two, ≥8
- SHW, $clog2(XLEN): shift-amount width, derived; do not override
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (state IDLE)
- op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 JALR, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU
- a, b  in  XLEN  operands (rs1, rs2/imm)
- pc  in  XLEN  PC of the instruction
- offset  in  XLEN  sign-extended branch/jump immediate
- out_valid  out  1  result registered and stable
- out_ready  in  1  consumer takes result
- result  out  XLEN  ALU/MDU result; PC+4 for JALR; 0 for branches
- branch_taken  out  1  redirect required
- branch_target  out  XLEN  redirect address
- err  out  1  unsupported op (divider compiled out)

## Operation
- FSM states: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE).
- Accept on in_valid && in_ready. Capture op, a, b, pc, and offset. Inputs are ignored after acceptance.
- Single-cycle ops (0–9): compute and register outputs, then IDLE→DONE.
- Shift ops use b[SHW-1:0] only. SRA is arithmetic.
- BEQ/BNE compare equality. BLT/BGE use signed comparison.
- For a taken branch, branch_target = pc+offset. For a not-taken branch, branch_taken=0 and branch_target=pc+4.
- JALR: branch_taken=1, branch_target=(a+offset)&~1, result=pc+4.
- All non-branch ops: branch_taken=0, branch_target=0.
- MUL/MULHU: unsigned shift-add, one bit per cycle, XLEN iterations in MUL, then DONE.
  - MUL returns the low XLEN bits of the 2·XLEN product; MULHU returns the high XLEN bits.
  - MUL low bits are sign-agnostic.
- DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle, XLEN iterations in DIV, then DONE.
  - Signed ops divide magnitudes, then fix signs: quotient negative iff the operand signs differ; remainder takes the sign of a.
- Fast paths go IDLE→DONE in one cycle:
  - Divide by zero: quotient = all ones, remainder = a.
  - Signed overflow (a=−2^(XLEN−1), b=−1): DIV = a, REM = 0.
- DONE holds out_valid=1 and all outputs stable until out_ready. Then go to IDLE.
  - A new op cannot be accepted in the same cycle (in_ready is still 0).
- Outside DONE, out_valid=0. The result/branch outputs hold their last values.

## Timing
- Reset, synchronous when rst_n=0 at the clock edge: state=IDLE, out_valid=0, result=0, branch_taken=0, branch_target=0, err=0, internal counters cleared.
- Reset during MUL/DIV/DONE aborts the operation. No result is produced.
- Latency is measured from the accept edge to the first cycle out_valid=1:
  - ops 0–9: 1 cycle
  - MUL/MULHU: XLEN+1 cycles
  - DIV family: XLEN+2 cycles (one extra cycle for sign fix)
  - fast paths: 1 cycle
- Minimum issue interval is 2 cycles (accept, DONE with out_ready=1).
- Iteration counter is SHW+1 bits wide. It runs from 0 to XLEN−1 with no wrap.
- All arithmetic is modulo 2^XLEN. The adder carry-out is discarded.

## Configuration
- ALU_MDU_DIV_EN defined: divider datapath and DIV state are built as above.
- Not defined: no divider logic. Ops 12–15 complete in 1 cycle with result=0, branch_taken=0, err=1.
- err is 0 for all other ops in both builds.

## Test plan
- ADD a=0xFFFFFFFF, b=1, out_ready=1 → out_valid one cycle after accept, result=0; SRA a=0x80000000, b=0x24 → 0xF8000000 (shift 4).
- BGE a=0xFFFFFFFE, b=1, pc=0x100, offset=0x20 → branch_taken=0, target=0x104. BLT with same operands → taken, target=0x120.
- JALR a=0x2001, offset=4, pc=0x40 → branch_taken=1, target=0x2004, result=0x44.
- MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE after 33 cycles. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- DIV a=−7, b=2 → result −3 (0xFFFFFFFD) after 34 cycles. REM same operands → 0xFFFFFFFF. DIVU b=0 → 0xFFFFFFFF in 1 cycle. DIV 0x80000000/−1 → 0x80000000.
- rst_n=0 at cycle 10 of a MUL → next cycle state IDLE, out_valid=0, in_ready=1. Without ALU_MDU_DIV_EN, DIV → err=1, result=0.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle RV32 execute unit (ALU, branch/JALR resolution, iterative MUL/DIV).
// Define ALU_MDU_DIV_EN to build the divider; without it ops 12-15 complete at once with err=1.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] offset,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            err
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] LAST = (SHW+1)'(XLEN-1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRL = 4'd3,
    OP_SRA = 4'd4, OP_BEQ = 4'd5, OP_BNE = 4'd6, OP_BLT = 4'd7, OP_BGE = 4'd8,
    OP_JALR = 4'd9, OP_MUL = 4'd10;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, result_q, res_d, target_q, tgt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mul_acc, div_acc;
  logic [SHW:0] cnt_q, cnt_d;
  logic taken_q, tk_d, err_q, err_d;
  logic accept, last, is_mul, is_div, eq, lt, alu_tk, div_go, div_fix, div_err;
  logic [XLEN-1:0] alu_res, alu_tgt, div_a, div_res, fast_res;
  logic [XLEN:0] mul_sum;
  assign accept = in_valid && in_ready;
  assign last = cnt_q == LAST;
  assign is_mul = op[3:1] == 3'b101;
  assign is_div = op[3:2] == 2'b11;
  assign eq = a == b;
  assign lt = $signed(a) < $signed(b);
  always_comb begin
    alu_res = '0;
    alu_tk = 1'b0;
    alu_tgt = '0;
    case (op)
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_SLL: alu_res = a << b[SHW-1:0];
      OP_SRL: alu_res = a >> b[SHW-1:0];
      OP_SRA: alu_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE: begin
        alu_tk = op == OP_BEQ ? eq : op == OP_BNE ? !eq : op == OP_BLT ? lt : !lt;
        alu_tgt = alu_tk ? pc + offset : pc + XLEN'(4);
      end
      OP_JALR: begin
        alu_tk = 1'b1;
        alu_tgt = (a + offset) & ~XLEN'(1);
        alu_res = pc + XLEN'(4);
      end
      default: ;
    endcase
  end
  // shift-add: add multiplicand into the high half when the low bit is set, then shift right
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
  logic [XLEN-1:0] b_q, b_d, a_mag, b_mag;
  logic negq_q, negq_d, negr_q, negr_d, fix_q, fix_d, sgn, ovf;
  logic [XLEN:0] diff;
  assign sgn = !op[0];
  assign a_mag = sgn && a[XLEN-1] ? -a : a;
  assign b_mag = sgn && b[XLEN-1] ? -b : b;
  assign ovf = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
  assign div_go = is_div && b != '0 && !ovf;
  assign div_a = a_mag;
  assign fast_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  // acc holds {remainder, dividend/quotient}; restore by keeping the shifted value on borrow
  assign diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign div_acc = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  assign div_fix = fix_q;
  assign div_res = op_q[1] ? (negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN])
                           : (negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign div_err = 1'b0;
  always_comb begin
    b_d = accept ? b_mag : b_q;
    negq_d = accept ? sgn && (a[XLEN-1] ^ b[XLEN-1]) : negq_q;
    negr_d = accept ? sgn && a[XLEN-1] : negr_q;
    fix_d = accept ? 1'b0 : (state_q == DIV && last) ? 1'b1 : fix_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      fix_q <= 1'b0;
    end else begin
      b_q <= b_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      fix_q <= fix_d;
    end
  end
`else
  assign div_go = 1'b0;
  assign div_a = '0;
  assign fast_res = '0;
  assign div_acc = '0;
  assign div_fix = 1'b0;
  assign div_res = '0;
  assign div_err = 1'b1;
`endif
  always_comb begin
    case (state_q)
      IDLE: state_d = !accept ? IDLE : is_mul ? MUL : div_go ? DIV : DONE;
      MUL: state_d = last ? DONE : MUL;
      DIV: state_d = div_fix ? DONE : DIV;
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    op_d = accept ? op : op_q;
    a_d = accept ? a : a_q;
    acc_d = accept ? {{XLEN{1'b0}}, is_div ? div_a : b}
          : state_q == MUL ? mul_acc
          : (state_q == DIV && !div_fix) ? div_acc : acc_q;
    cnt_d = accept ? '0 : ((state_q == MUL || state_q == DIV) && !last) ? cnt_q + 1'b1 : cnt_q;
    res_d = result_q;
    tk_d = taken_q;
    tgt_d = target_q;
    err_d = err_q;
    if (state_d == DONE && state_q != DONE) begin
      res_d = state_q == MUL ? (op_q == OP_MUL ? mul_acc[XLEN-1:0] : mul_acc[2*XLEN-1:XLEN])
            : state_q == DIV ? div_res : is_div ? fast_res : alu_res;
      tk_d = state_q == IDLE && alu_tk;
      tgt_d = state_q == IDLE ? alu_tgt : '0;
      err_d = state_q == IDLE && is_div && div_err;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      taken_q <= 1'b0;
      target_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      result_q <= res_d;
      taken_q <= tk_d;
      target_q <= tgt_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
  end
  assign result = result_q;
  assign branch_taken = taken_q;
  assign branch_target = target_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed vectors for alu_mdu checked against an arithmetic reference model.
module tb_alu_mdu;
  localparam int XLEN = 32;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SRL = 4'd3, SRA = 4'd4,
    BEQ = 4'd5, BNE = 4'd6, BLT = 4'd7, BGE = 4'd8, JALR = 4'd9, MUL = 4'd10,
    MULHU = 4'd11, DIV = 4'd12, DIVU = 4'd13, REM = 4'd14, REMU = 4'd15;
  typedef struct {
    logic [31:0] res;
    logic        tk;
    logic [31:0] tgt;
    logic        err;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0, pc = '0, offset = '0;
  logic in_ready, out_valid, branch_taken, err;
  logic [31:0] result, branch_target;
  int cyc = 0, pass = 0, total = 0;
  bit armed = 0;
  exp_t q[$];

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .pc(pc), .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken), .branch_target(branch_target), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, y, p, f);
    exp_t e;
    logic [63:0] prod;
    e.res = '0; e.tk = 1'b0; e.tgt = '0; e.err = 1'b0; e.lat = 1; e.acc = 0; e.seen = 0;
    prod = {32'd0, x} * {32'd0, y};
    case (o)
      ADD: e.res = x + y;
      SUB: e.res = x - y;
      SLL: e.res = x << y[4:0];
      SRL: e.res = x >> y[4:0];
      SRA: e.res = $signed(x) >>> y[4:0];
      BEQ, BNE, BLT, BGE: begin
        e.tk = o == BEQ ? x == y : o == BNE ? x != y : o == BLT ? $signed(x) < $signed(y) : $signed(x) >= $signed(y);
        e.tgt = e.tk ? p + f : p + 32'd4;
      end
      JALR: begin
        e.tk = 1'b1;
        e.tgt = (x + f) & 32'hFFFF_FFFE;
        e.res = p + 32'd4;
      end
      MUL, MULHU: begin
        e.res = o == MUL ? prod[31:0] : prod[63:32];
        e.lat = XLEN + 1;
      end
      default: begin
`ifdef ALU_MDU_DIV_EN
        if (y == 32'd0) e.res = (o == REM || o == REMU) ? x : 32'hFFFF_FFFF;
        else if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) e.res = o == REM ? 32'd0 : x;
        else begin
          e.lat = XLEN + 2;
          if (o == DIVU) e.res = x / y;
          else if (o == REMU) e.res = x % y;
          else if (o == DIV) e.res = $signed(x) / $signed(y);
          else e.res = $signed(x) % $signed(y);
        end
`else
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (armed && rst_n) begin
      if (q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      else if (out_valid) begin
        if (!q[0].seen) begin
          chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
          q[0].seen = 1;
        end
        chk("result", result, q[0].res);
        chk("taken", 32'(branch_taken), 32'(q[0].tk));
        chk("target", branch_target, q[0].tgt);
        chk("err", 32'(err), 32'(q[0].err));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, y, p, f, input int hold);
    exp_t e;
    int n;
    e = model(o, x, y, p, f);
    in_valid = 1'b1; op = o; a = x; b = y; pc = p; offset = f;
    out_ready = hold == 0;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; pc = $urandom; offset = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      chk("done_timeout", 32'(out_valid), 32'd1);
      q.delete();
      out_ready = 1'b1;
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass, total);
    $fatal(1);
  end

  initial begin
    exp_t e;
    e = model(ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("pin_add", e.res, 32'd0);
    e = model(SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0);
    chk("pin_sra", e.res, 32'hF800_0000);
    e = model(BGE, 32'hFFFF_FFFE, 32'd1, 32'h100, 32'h20);
    chk("pin_bge_tk", 32'(e.tk), 32'd0);
    chk("pin_bge_tgt", e.tgt, 32'h104);
    e = model(BLT, 32'hFFFF_FFFE, 32'd1, 32'h100, 32'h20);
    chk("pin_blt_tgt", e.tgt, 32'h120);
    e = model(JALR, 32'h2001, 32'd0, 32'h40, 32'd4);
    chk("pin_jalr_tgt", e.tgt, 32'h2004);
    chk("pin_jalr_res", e.res, 32'h44);
    e = model(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("pin_mulhu", e.res, 32'hFFFF_FFFE);
    chk("pin_mulhu_lat", 32'(e.lat), 32'd33);
`ifdef ALU_MDU_DIV_EN
    e = model(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    chk("pin_div", e.res, 32'hFFFF_FFFD);
    chk("pin_div_lat", 32'(e.lat), 32'd34);
    e = model(REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    chk("pin_rem", e.res, 32'hFFFF_FFFF);
    e = model(DIVU, 32'd5, 32'd0, 32'd0, 32'd0);
    chk("pin_divu0", e.res, 32'hFFFF_FFFF);
    chk("pin_divu0_lat", 32'(e.lat), 32'd1);
    e = model(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    chk("pin_div_ovf", e.res, 32'h8000_0000);
`else
    e = model(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    chk("pin_div_err", 32'(e.err), 32'd1);
    chk("pin_div_res", e.res, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_taken", 32'(branch_taken), 32'd0);
    chk("rst_target", branch_target, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    armed = 1;
    issue(ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0);
    issue(SUB, 32'd5, 32'd7, 32'd0, 32'd0, 0);
    issue(SLL, 32'd1, 32'h3F, 32'd0, 32'd0, 0);
    issue(SRL, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 0);
    issue(SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 0);
    issue(BEQ, 32'd9, 32'd9, 32'h200, 32'hFFFF_FFF0, 0);
    issue(BNE, 32'd9, 32'd9, 32'h200, 32'hFFFF_FFF0, 0);
    issue(BGE, 32'hFFFF_FFFE, 32'd1, 32'h100, 32'h20, 0);
    issue(BLT, 32'hFFFF_FFFE, 32'd1, 32'h100, 32'h20, 0);
    issue(JALR, 32'h2001, 32'd0, 32'h40, 32'd4, 0);
    issue(ADD, 32'd3, 32'd4, 32'd0, 32'd0, 2);
    issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5);
    issue(MUL, 32'd7, 32'd6, 32'd0, 32'd0, 0);
    issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 0);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0);
    issue(REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0);
    issue(DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 0);
    issue(REMU, 32'd5, 32'd0, 32'd0, 32'd0, 0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
    issue(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0);
    issue(DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 0);
    issue(REMU, 32'd100, 32'd7, 32'd0, 32'd0, 0);
    issue(DIV, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 0);
    issue(REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd0, 32'd0, 0);
    issue(SUB, 32'd1, 32'd1, 32'd0, 32'd0, 0);
    in_valid = 1'b1; op = MUL; a = 32'd123; b = 32'd456; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_result", result, 32'd0);
    repeat (40) begin @(posedge clk); #1; end
    issue(ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
